// File: rtl/axis_rgb565_gray.sv
// axis_rgb565_gray: converts an RGB565 AXI-Stream byte stream (high byte
// first) into 8-bit grayscale pixels. It reports the pixel count of each
// completed line and keeps a sticky flag for lines with an odd byte count.
// A single output register gives one pixel every two input beats, and
// s_tready_o depends only on the output register and m_tready_i.

module axis_rgb565_gray #(
  parameter int CNT_W_P = 12
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [7:0]         s_tdata_i,
  input  logic               s_tvalid_i,
  input  logic               s_tlast_i,
  output logic               s_tready_o,
  output logic [7:0]         m_tdata_o,
  output logic               m_tvalid_o,
  output logic               m_tlast_o,
  input  logic               m_tready_i,
  output logic [CNT_W_P-1:0] line_len_o,
  output logic               line_len_vld_o,
  output logic               err_odd_o
);

  // Byte phase within a pixel: the high byte comes first, then the low byte.
  typedef enum logic {
    PH_HI = 1'b0,
    PH_LO = 1'b1
  } phase_t;

  // RGB565 to 8-bit luma. Each channel is widened by repeating its MSBs,
  // then weighted 77/150/29. The weights add up to 256, so the 16-bit sum
  // cannot overflow and its upper byte is the result. There is no rounding.
  function automatic logic [7:0] rgb565_to_gray(input logic [7:0] hi,
                                                input logic [7:0] lo);
    logic [4:0]  r5;
    logic [5:0]  g6;
    logic [4:0]  b5;
    logic [7:0]  r8;
    logic [7:0]  g8;
    logic [7:0]  b8;
    logic [15:0] sum;
    r5  = hi[7:3];
    g6  = {hi[2:0], lo[7:5]};
    b5  = lo[4:0];
    r8  = {r5, r5[4:2]};
    g8  = {g6, g6[5:4]};
    b8  = {b5, b5[4:2]};
    sum = (16'd77  * {8'd0, r8})
        + (16'd150 * {8'd0, g8})
        + (16'd29  * {8'd0, b8});
    return sum[15:8];
  endfunction

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W_P-1:0] sat_inc(input logic [CNT_W_P-1:0] val);
    logic [CNT_W_P-1:0] res;
    if (&val) begin
      res = val;
    end else begin
      res = val + {{(CNT_W_P-1){1'b0}}, 1'b1};
    end
    return res;
  endfunction

  phase_t             phase_r;
  logic [7:0]         hi_r;
  logic [CNT_W_P-1:0] cnt_r;
  logic [7:0]         m_tdata_r;
  logic               m_tvalid_r;
  logic               m_tlast_r;
  logic [CNT_W_P-1:0] line_len_r;
  logic               line_len_vld_r;
  logic               err_odd_r;

  logic               ready_s;
  logic               accept_s;
  logic               hi_acc_s;
  logic               lo_acc_s;
  logic               odd_end_s;
  logic               line_end_s;
  logic               xfer_s;
  logic [7:0]         gray_s;

  // Upstream may send whenever the output slot is empty or is being drained.
  assign ready_s = ~m_tvalid_r | m_tready_i;

  // Decode the handshakes for this cycle and the pixel a low byte would form.
  always_comb begin
    accept_s   = 1'b0;
    hi_acc_s   = 1'b0;
    lo_acc_s   = 1'b0;
    odd_end_s  = 1'b0;
    line_end_s = 1'b0;
    xfer_s     = m_tvalid_r & m_tready_i;
    gray_s     = rgb565_to_gray(hi_r, s_tdata_i);
    if (s_tvalid_i && ready_s) begin
      accept_s = 1'b1;
      if (phase_r == PH_LO) begin
        lo_acc_s   = 1'b1;
        line_end_s = s_tlast_i;
      end else begin
        hi_acc_s  = 1'b1;
        odd_end_s = s_tlast_i;
      end
    end else begin
      accept_s = 1'b0;
    end
  end

  // Phase FSM. A tlast on a high byte ends the line early, so the phase
  // stays on the high byte to start the next line cleanly.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      phase_r <= PH_HI;
    end else if (accept_s) begin
      case (phase_r)
        PH_HI:   phase_r <= s_tlast_i ? PH_HI : PH_LO;
        PH_LO:   phase_r <= PH_HI;
        default: phase_r <= PH_HI;
      endcase
    end else begin
      phase_r <= phase_r;
    end
  end

  // Hold the high byte until its partner arrives. A high byte carrying
  // tlast is dropped.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hi_r <= 8'd0;
    end else if (hi_acc_s && !s_tlast_i) begin
      hi_r <= s_tdata_i;
    end else begin
      hi_r <= hi_r;
    end
  end

  // Output register. A new pixel overrides the drain, which keeps full
  // throughput when a pixel transfers in the same cycle a low byte arrives.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      m_tdata_r  <= 8'd0;
      m_tvalid_r <= 1'b0;
      m_tlast_r  <= 1'b0;
    end else if (lo_acc_s) begin
      m_tdata_r  <= gray_s;
      m_tvalid_r <= 1'b1;
      m_tlast_r  <= s_tlast_i;
    end else if (xfer_s) begin
      m_tdata_r  <= m_tdata_r;
      m_tvalid_r <= 1'b0;
      m_tlast_r  <= m_tlast_r;
    end else begin
      m_tdata_r  <= m_tdata_r;
      m_tvalid_r <= m_tvalid_r;
      m_tlast_r  <= m_tlast_r;
    end
  end

  // Per-line pixel counter. It saturates, and it clears at every line end,
  // including an odd-length line end.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_r <= {CNT_W_P{1'b0}};
    end else if (odd_end_s || line_end_s) begin
      cnt_r <= {CNT_W_P{1'b0}};
    end else if (lo_acc_s) begin
      cnt_r <= sat_inc(cnt_r);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Publish the completed line length with a one-cycle strobe. Odd-length
  // lines are not reported.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      line_len_r     <= {CNT_W_P{1'b0}};
      line_len_vld_r <= 1'b0;
    end else if (line_end_s) begin
      line_len_r     <= sat_inc(cnt_r);
      line_len_vld_r <= 1'b1;
    end else begin
      line_len_r     <= line_len_r;
      line_len_vld_r <= 1'b0;
    end
  end

  // Sticky flag for a line that ended on a high byte. Only reset clears it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_odd_r <= 1'b0;
    end else if (odd_end_s) begin
      err_odd_r <= 1'b1;
    end else begin
      err_odd_r <= err_odd_r;
    end
  end

  assign s_tready_o     = ready_s;
  assign m_tdata_o      = m_tdata_r;
  assign m_tvalid_o     = m_tvalid_r;
  assign m_tlast_o      = m_tlast_r;
  assign line_len_o     = line_len_r;
  assign line_len_vld_o = line_len_vld_r;
  assign err_odd_o      = err_odd_r;

endmodule

// File: doc/axis_rgb565_gray.md
AXIS_RGB565_GRAY -- requirements
Module: axis_rgb565_gray

Interface
REQ-001 Parameter CNT_W_P, default 12: width of the line-length counter.
REQ-002 clk_i  input  1  single pixel-domain clock; all logic rising-edge.
REQ-003 rst_i  input  1  reset; synchronous, active-high.
REQ-004 s_tdata_i  input  8  RGB565 byte stream, high byte first.
REQ-005 s_tvalid_i  input  1  input byte valid.
REQ-006 s_tlast_i  input  1  input byte is last of line.
REQ-007 s_tready_o  output  1  block accepts input byte this cycle.
REQ-008 m_tdata_o  output  8  grayscale pixel.
REQ-009 m_tvalid_o  output  1  output pixel valid.
REQ-010 m_tlast_o  output  1  output pixel is last of line.
REQ-011 m_tready_i  input  1  downstream ready.
REQ-012 line_len_o  output  CNT_W_P  pixel count of last completed line.
REQ-013 line_len_vld_o  output  1  one-cycle pulse when line_len_o updates.
REQ-014 err_odd_o  output  1  sticky flag: line ended on a high byte.

Function
REQ-015 Input beat accepted iff s_tvalid_i & s_tready_o; output beat transferred iff m_tvalid_o & m_tready_i.
REQ-016 s_tready_o = ~m_tvalid_o | m_tready_i (single output register, no combinational path from s_tvalid_i to s_tready_o).
REQ-017 Phase bit: 0 = expecting high byte, 1 = expecting low byte; toggles on each accepted beat.
REQ-018 Phase 0 accept: store byte in hi register; no output produced.
REQ-019 Phase 1 accept: R5 = hi[7:3], G6 = {hi[2:0], byte[7:5]}, B5 = byte[4:0].
REQ-020 Expansion: R8 = {R5, R5[4:2]}, G8 = {G6, G6[5:4]}, B8 = {B5, B5[4:2]}.
REQ-021 Gray = (77*R8 + 150*G8 + 29*B8) >> 8; 16-bit unsigned sum, truncation, no rounding; result fits 8 bits.
REQ-022 On phase-1 accept: m_tdata_o <= Gray, m_tvalid_o <= 1, m_tlast_o <= s_tlast_i, all on the next clock edge (latency 1 cycle from low-byte accept).
REQ-023 m_tdata_o/m_tlast_o hold stable while m_tvalid_o=1 & m_tready_i=0.
REQ-024 On output transfer with no new phase-1 accept in the same cycle: m_tvalid_o <= 0.
REQ-025 Transfer and phase-1 accept in same cycle: output register reloads with the new pixel; m_tvalid_o stays 1 (full throughput, one pixel every 2 input beats).
REQ-026 Pixel counter increments on each phase-1 accept; on phase-1 accept with s_tlast_i=1: line_len_o <= count+1, line_len_vld_o pulses 1 cycle, counter <= 0.
REQ-027 Counter saturates at all-ones; no wrap.
REQ-028 s_tlast_i on a phase-0 accept (odd byte count): byte discarded, no output, phase forced to 0, counter cleared, line_len_o unchanged, no pulse, err_odd_o <= 1.
REQ-029 err_odd_o cleared only by reset.

Reset
REQ-030 While rst_i=1 at a clock edge: phase=0, hi=0, counter=0, m_tdata_o=0, m_tvalid_o=0, m_tlast_o=0, line_len_o=0, line_len_vld_o=0, err_odd_o=0.
REQ-031 s_tready_o=1 out of reset (derives from m_tvalid_o=0).
REQ-032 Reset mid-line discards stored high byte and any undelivered output pixel; next accepted byte is a high byte.

Verification
REQ-033 Bytes 0xFF,0xFF (tlast on 2nd), m_tready_i=1 -> m_tdata_o=0xFF, m_tlast_o=1 one cycle after 2nd byte; line_len_o=1, line_len_vld_o pulse.
REQ-034 Pairs F8 00 / 07 E0 / 00 1F / 00 00 -> outputs 76, 149, 28, 0 in order.
REQ-035 Stream 640 pairs with tlast on byte 1280, m_tready_i toggling 1/0 -> 640 pixels, no loss/duplication, m_tlast_o only on pixel 640, line_len_o=640, data stable during stalls.
REQ-036 3-byte line, tlast on 3rd byte -> one pixel (tlast=0), err_odd_o=1, no line_len_vld_o; next line starts with high byte.
REQ-037 Assert rst_i after a high byte and while m_tvalid_o=1 stalled -> next cycle all outputs 0, s_tready_o=1; following pair 0xFF,0xFF yields 0xFF.
REQ-038 Hold m_tready_i=0 with pending pixel -> s_tready_o=0, input beats not accepted, phase unchanged.
